// File: rtl/fft_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_sequencer
// Description : Control FSM for a 64-point radix-2 in-place FFT core. It runs
//               each frame through three phases: sample load, then 6 butterfly
//               levels of 32 butterflies each, then result readout. It also
//               produces the issue/writeback timing for the butterfly datapath
//               and the ping-pong RAM banks.
//               Optional feature macro: FFT_SEQ_ABORT_EN (adds an abort input).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_sequencer #(
    parameter int BFLY_LATENCY = 2,   // issue-to-writeback cycles, 1..8
    parameter int AUTO_RESTART = 0    // 1: DONE -> LOAD, 0: DONE -> IDLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef FFT_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       load,
    output logic       processing,
    output logic       done,
    output logic [5:0] load_address,
    output logic [5:0] fft_level,
    output logic [5:0] butterfly_iter,
    output logic       issue_valid,
    output logic       rd_bank,
    output logic       wr_en,
    output logic [5:0] wr_level,
    output logic [5:0] wr_iter,
    output logic [5:0] out_address,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] c_DRAIN_LAST = 3'(BFLY_LATENCY - 1);
    localparam logic [5:0] c_LAST_ADDR  = 6'd63;
    localparam logic [5:0] c_LAST_ITER  = 6'd31;
    localparam logic [5:0] c_LAST_LEVEL = 6'd5;

    state_t     r_state;
    logic [5:0] r_load_addr;
    logic [5:0] r_iter;
    logic [5:0] r_level;
    logic [5:0] r_out_addr;
    logic [2:0] r_drain_cnt;

    logic       r_load;
    logic       r_proc;
    logic       r_issue;
    logic       r_done;
    logic       r_busy;

    // Write pipeline stages; index BFLY_LATENCY-1 is the writeback stage.
    logic       r_pipe_vld [BFLY_LATENCY];
    logic [5:0] r_pipe_lvl [BFLY_LATENCY];
    logic [5:0] r_pipe_itr [BFLY_LATENCY];

    state_t     w_next_state;
    logic       w_abort;
    logic       w_load_acc;
    logic       w_load_last;
    logic       w_iter_last;
    logic       w_drain_last;
    logic       w_out_xfer;
    logic       w_out_last;

`ifdef FFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state decode; abort overrides every handshake and transition.
    always_comb begin
        w_next_state = r_state;
        w_load_acc   = (r_state == S_LOAD) && sample_valid;
        w_load_last  = w_load_acc && (r_load_addr == c_LAST_ADDR);
        w_iter_last  = (r_state == S_ISSUE) && (r_iter == c_LAST_ITER);
        w_drain_last = (r_state == S_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
        w_out_xfer   = (r_state == S_DONE) && out_ready;
        w_out_last   = w_out_xfer && (r_out_addr == c_LAST_ADDR);
        case (r_state)
            S_IDLE:  if (start)        w_next_state = S_LOAD;
            S_LOAD:  if (w_load_last)  w_next_state = S_ISSUE;
            S_ISSUE: if (w_iter_last)  w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_last) w_next_state = (r_level == c_LAST_LEVEL) ? S_DONE : S_ISSUE;
            S_DONE:  if (w_out_last)   w_next_state = (AUTO_RESTART != 0) ? S_LOAD : S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
        end
    end

    // State register, counters and state-decoded outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_load_addr <= '0;
            r_iter      <= '0;
            r_level     <= '0;
            r_out_addr  <= '0;
            r_drain_cnt <= '0;
            r_load      <= 1'b0;
            r_proc      <= 1'b0;
            r_issue     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_load  <= (w_next_state == S_LOAD);
            r_proc  <= (w_next_state == S_ISSUE) || (w_next_state == S_DRAIN);
            r_issue <= (w_next_state == S_ISSUE);
            r_done  <= (w_next_state == S_DONE);
            r_busy  <= (w_next_state != S_IDLE);
            if (w_abort) begin
                r_load_addr <= '0;
                r_iter      <= '0;
                r_level     <= '0;
                r_out_addr  <= '0;
                r_drain_cnt <= '0;
            end else begin
                // 6-bit counters wrap 63 -> 0 on the final accept/transfer.
                if (w_load_acc) begin
                    r_load_addr <= r_load_addr + 6'd1;
                end
                if (r_state == S_ISSUE) begin
                    r_iter <= w_iter_last ? 6'd0 : r_iter + 6'd1;
                end
                if (r_state == S_DRAIN) begin
                    r_drain_cnt <= w_drain_last ? 3'd0 : r_drain_cnt + 3'd1;
                end
                if (w_drain_last) begin
                    r_level <= (r_level == c_LAST_LEVEL) ? 6'd0 : r_level + 6'd1;
                end
                if (w_out_xfer) begin
                    r_out_addr <= r_out_addr + 6'd1;
                end
            end
        end
    end

    // Writeback delay line: shifts every cycle, flushed by reset or abort.
    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_lvl[i] <= '0;
                r_pipe_itr[i] <= '0;
            end
        end else begin
            for (int i = BFLY_LATENCY - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_lvl[i] <= r_pipe_lvl[i-1];
                r_pipe_itr[i] <= r_pipe_itr[i-1];
            end
            r_pipe_vld[0] <= r_issue;
            r_pipe_lvl[0] <= r_level;
            r_pipe_itr[0] <= r_iter;
        end
    end

    assign sample_ready   = r_load;
    assign load           = r_load;
    assign processing     = r_proc;
    assign done           = r_done;
    assign out_valid      = r_done;
    assign busy           = r_busy;
    assign issue_valid    = r_issue;
    assign load_address   = r_load_addr;
    assign fft_level      = r_level;
    assign butterfly_iter = r_iter;
    assign out_address    = r_out_addr;
    assign rd_bank        = r_level[0];
    assign wr_en          = r_pipe_vld[BFLY_LATENCY-1];
    assign wr_level       = r_pipe_lvl[BFLY_LATENCY-1];
    assign wr_iter        = r_pipe_itr[BFLY_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_sequencer
// Description : Self-checking bench for fft_sequencer. A frame-level model
//               (phase plus accept/cycle/transfer counts) predicts every
//               output each cycle; exercised with FFT_SEQ_ABORT_EN too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_sequencer;

    localparam int LAT  = 2;
    localparam int AR   = 0;
    localparam int SPAN = 32 + LAT;

    logic       clk = 1'b0;
    logic       reset, start, abort, sample_valid, out_ready;
    logic       sample_ready, load, processing, done, issue_valid, rd_bank;
    logic       wr_en, out_valid, busy;
    logic [5:0] load_address, fft_level, butterfly_iter, wr_level, wr_iter, out_address;

    int n_checks = 0;
    int n_errors = 0;

    fft_sequencer #(.BFLY_LATENCY(LAT), .AUTO_RESTART(AR)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef FFT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .sample_valid(sample_valid), .sample_ready(sample_ready), .load(load),
        .processing(processing), .done(done), .load_address(load_address),
        .fft_level(fft_level), .butterfly_iter(butterfly_iter),
        .issue_valid(issue_valid), .rd_bank(rd_bank), .wr_en(wr_en),
        .wr_level(wr_level), .wr_iter(wr_iter), .out_address(out_address),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame model: 0 idle, 1 load, 2 process, 3 done
    int m_phase = 0, m_nload = 0, m_k = 0, m_nout = 0;
    int m_hv[$], m_hl[$], m_hi[$];   // expected issue history, oldest first

    function automatic int e_issue();
        return (m_phase == 2 && (m_k % SPAN) < 32) ? 1 : 0;
    endfunction
    function automatic int e_level();
        return (m_phase == 2) ? m_k / SPAN : 0;
    endfunction
    function automatic int e_iter();
        return (e_issue() != 0) ? m_k % SPAN : 0;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_nload = 0; m_k = 0; m_nout = 0;
        m_hv.delete(); m_hl.delete(); m_hi.delete();
        for (int i = 0; i < LAT; i++) begin
            m_hv.push_back(0); m_hl.push_back(0); m_hi.push_back(0);
        end
    endtask

    task automatic model_edge(input bit rst, st, sv, ordy, ab);
        if (rst || ab) begin
            model_clear();
        end else begin
            m_hv.push_back(e_issue()); m_hl.push_back(e_level()); m_hi.push_back(e_iter());
            void'(m_hv.pop_front()); void'(m_hl.pop_front()); void'(m_hi.pop_front());
            case (m_phase)
                0: if (st) m_phase = 1;
                1: if (sv) begin
                       m_nload++;
                       if (m_nload == 64) begin m_nload = 0; m_k = 0; m_phase = 2; end
                   end
                2: begin
                       m_k++;
                       if (m_k == 6 * SPAN) begin m_k = 0; m_phase = 3; end
                   end
                default: if (ordy) begin
                       m_nout++;
                       if (m_nout == 64) begin m_nout = 0; m_phase = (AR != 0) ? 1 : 0; end
                   end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy",           32'(busy),           32'(m_phase != 0));
        chk("load",           32'(load),           32'(m_phase == 1));
        chk("sample_ready",   32'(sample_ready),   32'(m_phase == 1));
        chk("processing",     32'(processing),     32'(m_phase == 2));
        chk("done",           32'(done),           32'(m_phase == 3));
        chk("out_valid",      32'(out_valid),      32'(m_phase == 3));
        chk("issue_valid",    32'(issue_valid),    32'(e_issue()));
        chk("load_address",   32'(load_address),   32'((m_phase == 1) ? m_nload : 0));
        chk("fft_level",      32'(fft_level),      32'(e_level()));
        chk("butterfly_iter", 32'(butterfly_iter), 32'(e_iter()));
        chk("rd_bank",        32'(rd_bank),        32'(e_level() % 2));
        chk("out_address",    32'(out_address),    32'((m_phase == 3) ? m_nout : 0));
        chk("wr_en",          32'(wr_en),          32'(m_hv[0]));
        chk("wr_level",       32'(wr_level),       32'(m_hl[0]));
        chk("wr_iter",        32'(wr_iter),        32'(m_hi[0]));
    endtask

    task automatic step(input bit rst, st, sv, ordy, ab);
        reset = rst; start = st; sample_valid = sv; out_ready = ordy; abort = ab;
        @(posedge clk);
        model_edge(rst, st, sv, ordy, ab);
        #1;
        check_all();
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s observed=timeout expected=reached", tag);
    endtask

    task automatic rnd_step();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        bit ok;
        bit pat4[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit pat5[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        model_clear();
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);

        // Frame 1: back-to-back load
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1'($urandom_range(0, 1)), 1, 0, 0);

        // Full processing span with ignored inputs
        for (int i = 0; i < 6 * SPAN; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        // Readout: fixed ready pattern then random until idle
        for (int i = 0; i < 5; i++) step(0, 0, 0, pat5[i], 0);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step(0, 0, 0, 1'($urandom_range(0, 1)), 0);
            ok = (m_phase == 0);
        end
        if (!ok) timeout("readout_end");

        // Frame 2: gapped load pattern, then reset mid-processing at level 3 iter 17
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step(0, 0, pat4[i % 4], 0, 0);
            ok = (m_phase == 2);
        end
        if (!ok) timeout("gapped_load");
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = (m_phase == 2 && e_level() == 3 && e_iter() == 17);
            if (!ok) step(0, 0, 0, 0, 0);
        end
        if (!ok) timeout("reach_l3_i17");
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);

        // Frames after reset: fully random handshakes
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) rnd_step();

`ifdef FFT_SEQ_ABORT_EN
        // Abort during DRAIN
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = (m_phase == 2 && e_level() == 2 && (m_k % SPAN) == 33);
            if (!ok) step(0, 0, 0, 0, 0);
        end
        if (!ok) timeout("reach_drain");
        step(0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        // Abort and start together in IDLE
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Abort in LOAD and DONE phases at random points
        for (int i = 0; i < 600; i++) begin
            reset = 0;
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Control FSM for the 64-point radix-2 in-place FFT core.
- Drives the control side of the address generation unit: load, processing, done, fft_level, butterfly_iter, load_address and out_address.
- Steps a frame through three phases in order: sample load, 6 butterfly levels of 32 butterflies each, then result readout.
- Provides the issue/writeback timing for the butterfly datapath and the ping-pong RAM banks.

Parameters:
- BFLY_LATENCY, 2, cycles from butterfly issue (read address) to writeback (write address). Legal range 1..8.
- AUTO_RESTART, 0, when 1 the block goes DONE -> LOAD on frame end. When 0 it goes DONE -> IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- sample_valid  in  1  input sample present this cycle
- sample_ready  out  1  high throughout LOAD
- load  out  1  AGU load select; high in LOAD
- processing  out  1  high in ISSUE and DRAIN
- done  out  1  AGU done select; high in DONE
- load_address  out  6  natural-order index of the current input sample; the AGU bit-reverses it
- fft_level  out  6  current level, 0..5
- butterfly_iter  out  6  current butterfly, 0..31
- issue_valid  out  1  a butterfly read is issued this cycle
- rd_bank  out  1  equals fft_level[0]; 0 = read bank 0 / write bank 1
- wr_en  out  1  issue_valid delayed BFLY_LATENCY cycles
- wr_level  out  6  fft_level delayed BFLY_LATENCY cycles
- wr_iter  out  6  butterfly_iter delayed BFLY_LATENCY cycles
- out_address  out  6  result index presented to the AGU
- out_valid  out  1  high in DONE
- out_ready  in  1  consumer accepts the current out_address
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- Reset: state IDLE. All outputs and delay-pipeline stages are 0 on the cycle after reset is sampled high. This applies equally to reset mid-frame; no partial frame is resumed.
- IDLE:
  - start=1 -> LOAD next cycle.
  - All counters are 0.
- LOAD:
  - Each cycle with sample_valid=1 is one accepted sample, written by the datapath at load_address.
  - load_address increments by 1 per accept and holds during gaps.
  - Accept at load_address=63 -> ISSUE next cycle, load_address wraps to 0.
- ISSUE:
  - issue_valid=1 every cycle.
  - butterfly_iter increments 0..31.
  - After the cycle with butterfly_iter=31 -> DRAIN, butterfly_iter returns to 0.
- DRAIN:
  - Lasts exactly BFLY_LATENCY cycles with issue_valid=0 and fft_level held, so all writes for the level land before the next level reads.
  - On the last DRAIN cycle: if fft_level<5, fft_level increments and the next state is ISSUE; if fft_level=5, fft_level returns to 0 and the next state is DONE.
  - processing stays high throughout.
  - Total processing span is 6*(32+BFLY_LATENCY) cycles.
- Write pipeline:
  - wr_en, wr_level and wr_iter are a BFLY_LATENCY-deep shift of issue_valid, fft_level and butterfly_iter.
  - The pipeline shifts every cycle regardless of state.
  - The final write of level 5 completes on the last DRAIN cycle, before done rises.
- Bank usage:
  - Level L reads bank L[0] and writes the other bank.
  - The result ends in bank 0, which is also the LOAD target.
- DONE:
  - out_valid=1.
  - out_address advances by 1 on each cycle with out_ready=1 and holds otherwise.
  - Transfer at out_address=63 -> IDLE, or LOAD if AUTO_RESTART=1. out_address wraps to 0.
- Outside their own state, load_address, butterfly_iter, fft_level and out_address read 0.
- start outside IDLE is ignored. sample_valid outside LOAD is ignored. out_ready outside DONE is ignored.

Optional Feature:
- Macro: FFT_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in any state forces IDLE next cycle.
  - All counters clear, issue_valid clears and the write pipeline is flushed (wr_en=0 from the next cycle).
  - abort has priority over start and all handshakes; reset still has priority over abort.
- When undefined: no abort port exists and the frame always runs to completion.

Test Plan:
- Reset, start=1, then 64 back-to-back sample_valid -> load_address steps 0..63; load falls and processing/issue_valid rise on the cycle after the 64th accept.
- LOAD with sample_valid toggling 1,0,0,1 -> load_address holds during gaps; exactly 64 accepts are needed to leave LOAD.
- BFLY_LATENCY=2, full process -> per level 32 issue_valid cycles then a 2-cycle gap; 6 levels in 204 cycles; wr_en/wr_iter/wr_level equal issue_valid/butterfly_iter/fft_level 2 cycles earlier; rd_bank follows 0,1,0,1,0,1.
- DONE with out_ready pattern 1,0,1,1,0 -> out_address advances only on ready cycles; after the 64th transfer, IDLE (AUTO_RESTART=0) or LOAD with sample_ready=1 (AUTO_RESTART=1).
- reset pulsed during ISSUE at fft_level=3, butterfly_iter=17 -> next cycle busy=0, fft_level=0, wr_en=0 and stays 0; a new start runs a full frame.
- FFT_SEQ_ABORT_EN defined, abort in DRAIN -> IDLE next cycle, wr_en=0 with no trailing writes; abort and start in the same IDLE cycle -> stays IDLE.
